// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared constants, FSM state type and command packing for the
// SPI draw-command transmitter.
//   CMD_BITS         width of one serialised command {x, y, data}
//   X_MSB/Y_MSB/D_MSB bit positions of each field's MSB in the command word
//   FIELD_W          width of each command field
//   state_e          transmitter FSM states
//   pack_cmd()       assembles the 24-bit command word
package spi_cmd_pkg;

    localparam int unsigned CMD_BITS = 24;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned X_MSB    = 23;
    localparam int unsigned Y_MSB    = 15;
    localparam int unsigned D_MSB    = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4
    } state_e;

    function automatic logic [CMD_BITS-1:0] pack_cmd(
        input logic [FIELD_W-1:0] x,
        input logic [FIELD_W-1:0] y,
        input logic [FIELD_W-1:0] d
    );
        return {x, y, d};
    endfunction

endpackage

// File: rtl/spi_cmd_tx_if.sv
// spi_cmd_tx_if: valid/ready command handshake between upstream game logic
// and the SPI command transmitter.
//   cmd_valid  command on x/y/data is valid (driven by master)
//   x, y, data command fields, bits [23:16], [15:8], [7:0]
//   cmd_ready  transmitter is idle and accepts a command (driven by slave)
// Modports: master = command producer, slave = transmitter.
interface spi_cmd_tx_if;
    import spi_cmd_pkg::*;

    logic               cmd_valid;
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
    logic [FIELD_W-1:0] data;
    logic               cmd_ready;

    modport master (
        output cmd_valid,
        output x,
        output y,
        output data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  x,
        input  y,
        input  data,
        output cmd_ready
    );

endinterface

// File: rtl/spi_half_tick.sv
// spi_half_tick: reloadable down-counter timing SPI half-periods and the
// inter-frame gap.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   load      reload the counter with load_val (has priority)
//   load_val  number of cycles until the next tick
//   tick      high during the last cycle of a loaded interval
// A load of N makes tick assert N-1 cycles later, so a state that reloads on
// entry and leaves on tick lasts exactly N cycles. The counter rests at 0.
module spi_half_tick #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_cmd_tx.sv
// spi_cmd_tx: serialises one 24-bit draw command {x, y, data} per frame onto
// the SPI_CLK / SPI_CS / SPI_DATA link, MSB first. The receiver shifts on
// each SPI_CLK falling edge and commits on the SPI_CS rising edge.
//   CLOCK_50  system clock
//   RESET_N   asynchronous active-low reset
//   cmd       command handshake (slave side)
//   SPI_CLK   serial clock, idles low
//   SPI_CS    active-low frame select, idles high
//   SPI_DATA  serial data, idles low
//   busy      frame or inter-frame gap in progress
//   done      one-cycle pulse coinciding with SPI_CS returning high
// Parameters: CLK_DIV (cycles per SPI_CLK half-period, >= 1) and
// GAP_CYCLES (cycles spent in the gap state after each frame, >= 1).
module spi_cmd_tx
    import spi_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    spi_cmd_tx_if.slave       cmd,
    output logic              SPI_CLK,
    output logic              SPI_CS,
    output logic              SPI_DATA,
    output logic              busy,
    output logic              done
);

    // One timer serves both the half-period and the gap, so it is sized
    // for the larger of the two intervals.
    localparam int unsigned CNT_MAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned TW       = $clog2(CNT_MAX + 1);
    localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES);
    localparam logic [4:0]    LAST_BIT = 5'(CMD_BITS - 1);

    state_e              state;
    logic [CMD_BITS-1:0] shreg;
    logic [CMD_BITS-1:0] cmd_word;
    logic [4:0]          bit_cnt;
    logic                cmd_ready_q;
    logic                accept;
    logic                last_bit;
    logic                tick;
    logic                load;
    logic [TW-1:0]       load_val;

    assign cmd_word      = pack_cmd(cmd.x, cmd.y, cmd.data);
    assign cmd.cmd_ready = cmd_ready_q;

    // cmd_ready_q is only ever high in IDLE, so it alone qualifies accept.
    assign accept   = cmd_ready_q && cmd.cmd_valid;
    assign last_bit = (bit_cnt == LAST_BIT);

    // Every timed state reloads the timer on entry; the entry into GAP
    // (end of the last LOW) loads the gap length instead.
    assign load     = accept || (tick && (state inside {SETUP, HIGH, LOW}));
    assign load_val = (state == LOW && last_bit) ? GAP_LOAD : DIV_LOAD;

    spi_half_tick #(
        .CNT_W (TW)
    ) u_half_tick (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .load     (load),
        .load_val (load_val),
        .tick     (tick)
    );

    // SPI outputs are updated on the same edge as the state transition that
    // defines them, so every output is a flop with no path from the inputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            cmd_ready_q <= 1'b0;
            SPI_CLK     <= 1'b0;
            SPI_CS      <= 1'b1;
            SPI_DATA    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        shreg       <= cmd_word;
                        bit_cnt     <= '0;
                        cmd_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        SPI_CS      <= 1'b0;
                        SPI_DATA    <= cmd_word[X_MSB];
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        SPI_CLK <= 1'b1;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        SPI_CLK <= 1'b0;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (!last_bit) begin
                            // Next bit goes out together with the rising edge.
                            shreg    <= {shreg[CMD_BITS-2:0], 1'b0};
                            SPI_DATA <= shreg[CMD_BITS-2];
                            bit_cnt  <= bit_cnt + 5'd1;
                            SPI_CLK  <= 1'b1;
                            state    <= HIGH;
                        end else begin
                            SPI_CS   <= 1'b1;
                            SPI_DATA <= 1'b0;
                            done     <= 1'b1;
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy        <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_tx.sv
// tb_spi_cmd_tx: directed self-checking bench for spi_cmd_tx.
// Two instances share clock and reset: index 0 uses CLK_DIV=2/GAP_CYCLES=8,
// index 1 uses CLK_DIV=1/GAP_CYCLES=3. A receiver model per instance shifts
// SPI_DATA on SPI_CLK falling edges while SPI_CS is low and latches the word
// on the SPI_CS rising edge; it also flags any framing rule violation.
module tb_spi_cmd_tx;
    import spi_cmd_pkg::*;

    localparam int DIV0 = 2;
    localparam int GAP0 = 8;
    localparam int DIV1 = 1;
    localparam int GAP1 = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] spi_clk;
    logic [1:0] spi_cs;
    logic [1:0] spi_dat;
    logic [1:0] busy_o;
    logic [1:0] done_o;
    logic [1:0] rdy;

    spi_cmd_tx_if bus0 ();
    spi_cmd_tx_if bus1 ();

    assign rdy = {bus1.cmd_ready, bus0.cmd_ready};

    spi_cmd_tx #(.CLK_DIV(DIV0), .GAP_CYCLES(GAP0)) dut0 (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .cmd      (bus0),
        .SPI_CLK  (spi_clk[0]),
        .SPI_CS   (spi_cs[0]),
        .SPI_DATA (spi_dat[0]),
        .busy     (busy_o[0]),
        .done     (done_o[0])
    );

    spi_cmd_tx #(.CLK_DIV(DIV1), .GAP_CYCLES(GAP1)) dut1 (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .cmd      (bus1),
        .SPI_CLK  (spi_clk[1]),
        .SPI_CS   (spi_cs[1]),
        .SPI_DATA (spi_dat[1]),
        .busy     (busy_o[1]),
        .done     (done_o[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- receiver / framing monitor ----------------
    int          frames[2];
    int          falls[2];
    int          last_falls[2];
    int          lo_len[2];
    int          last_low[2];
    int          hi_len[2];
    int          last_high[2];
    int          since_fall[2];
    int          last_period[2];
    int          run[2];
    int          viol[2];
    int          done_cnt[2];
    logic [23:0] rx_sr[2];
    logic [23:0] rx_word[2];
    logic [23:0] hist[2][16];
    logic [1:0]  prev_sclk = 2'b00;
    logic [1:0]  prev_cs   = 2'b11;
    logic [1:0]  prev_dat  = 2'b00;
    logic        prev_rst  = 1'b0;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int div;
            div = (d == 0) ? DIV0 : DIV1;
            if (rst_n && prev_rst) begin
                since_fall[d]++;
                if (spi_cs[d] && spi_clk[d]) viol[d]++;
                if (spi_cs[d] && spi_dat[d]) viol[d]++;
                if (prev_cs[d] && !spi_cs[d]) begin
                    if (spi_clk[d]) viol[d]++;
                    last_high[d]   = hi_len[d];
                    last_period[d] = since_fall[d];
                    since_fall[d]  = 0;
                    lo_len[d]      = 1;
                    run[d]         = 1;
                    falls[d]       = 0;
                    rx_sr[d]       = '0;
                end else if (!spi_cs[d]) begin
                    lo_len[d]++;
                    if (spi_clk[d] != prev_sclk[d]) begin
                        if (run[d] != div) viol[d]++;
                        run[d] = 1;
                    end else begin
                        run[d]++;
                    end
                    if (prev_sclk[d] && !spi_clk[d]) begin
                        rx_sr[d] = {rx_sr[d][22:0], spi_dat[d]};
                        falls[d]++;
                    end
                    // data may only move together with a rising SPI_CLK
                    if (spi_dat[d] != prev_dat[d] && !(!prev_sclk[d] && spi_clk[d])) viol[d]++;
                end else if (!prev_cs[d]) begin
                    if (run[d] != div) viol[d]++;
                    last_low[d]   = lo_len[d];
                    last_falls[d] = falls[d];
                    rx_word[d]    = rx_sr[d];
                    if (frames[d] < 16) hist[d][frames[d]] = rx_sr[d];
                    frames[d]++;
                    hi_len[d] = 1;
                end else begin
                    hi_len[d]++;
                end
                if (done_o[d] && !(spi_cs[d] && !prev_cs[d])) viol[d]++;
                if (spi_cs[d] && !prev_cs[d] && !done_o[d]) viol[d]++;
                if (done_o[d]) done_cnt[d]++;
            end
            prev_sclk[d] = spi_clk[d];
            prev_cs[d]   = spi_cs[d];
            prev_dat[d]  = spi_dat[d];
        end
        prev_rst = rst_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cmd(input int d, input logic v, input logic [23:0] w);
        if (d == 0) begin
            bus0.cmd_valid = v;
            bus0.x = w[23:16]; bus0.y = w[15:8]; bus0.data = w[7:0];
        end else begin
            bus1.cmd_valid = v;
            bus1.x = w[23:16]; bus1.y = w[15:8]; bus1.data = w[7:0];
        end
    endtask

    // valid must already be high; returns 1 time unit after the accept edge
    task automatic wait_accept(input int d, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            if (rdy[d]) seen = 1'b1;
            else n++;
        end
        if (seen) begin
            @(posedge clk);
            #1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic send(input int d, input logic [23:0] w, input string tag);
        set_cmd(d, 1'b1, w);
        wait_accept(d, tag);
        set_cmd(d, 1'b0, w);
    endtask

    task automatic wait_frames(input int d, input int target, input string tag);
        int n = 0;
        while (frames[d] < target && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(frames[d] >= target), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int dc0;
        set_cmd(0, 1'b0, 24'h0);
        set_cmd(1, 1'b0, 24'h0);

        // ---- reset values ----
        #2 rst_n = 1'b0;
        #20;
        check("rst_cs",    32'(spi_cs[0]),  32'd1);
        check("rst_clk",   32'(spi_clk[0]), 32'd0);
        check("rst_data",  32'(spi_dat[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]),     32'd0);
        check("rst_busy",  32'(busy_o[0]),  32'd0);
        check("rst_done",  32'(done_o[0]),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(rdy[0]), 32'd1);
        check("ready_after_rst1", 32'(rdy[1]), 32'd1);

        // ---- single frame, CLK_DIV=2 ----
        dc0 = done_cnt[0];
        send(0, 24'h123456, "acc_single");
        check("cs_fall_at_accept", 32'(spi_cs[0]),  32'd0);
        check("bit23_at_accept",   32'(spi_dat[0]), 32'd0);
        check("busy_in_frame",     32'(busy_o[0]),  32'd1);
        check("ready_in_frame",    32'(rdy[0]),     32'd0);
        wait_frames(0, 1, "frame_single");
        check("single_word",  32'(rx_word[0]),    32'h123456);
        check("single_falls", 32'(last_falls[0]), 32'd24);
        check("single_cs_low", 32'(last_low[0]),  32'd98);
        check("single_done",  32'(done_cnt[0] - dc0), 32'd1);
        check("single_viol",  32'(viol[0]),       32'd0);

        // ---- x changes right after the accept ----
        idle_cycles(20);
        send(0, 24'hAA1234, "acc_midchg");
        set_cmd(0, 1'b0, 24'h551234);
        wait_frames(0, 2, "frame_midchg");
        check("midchg_x", 32'(rx_word[0][X_MSB -: 8]), 32'hAA);
        check("midchg_word", 32'(rx_word[0]), 32'hAA1234);

        // ---- back-to-back with valid held high ----
        idle_cycles(20);
        f0 = frames[0];
        set_cmd(0, 1'b1, 24'hFFFFFF);
        wait_accept(0, "acc_b2b_a");
        set_cmd(0, 1'b1, 24'h000000);
        wait_accept(0, "acc_b2b_b");
        set_cmd(0, 1'b0, 24'h000000);
        wait_frames(0, f0 + 2, "frame_b2b");
        check("b2b_word_a", 32'(hist[0][f0]),     32'hFFFFFF);
        check("b2b_word_b", 32'(hist[0][f0 + 1]), 32'h000000);
        // CS high across the gap: GAP0 cycles of gap plus the one IDLE accept cycle
        check("b2b_cs_high", 32'(last_high[0]),   32'(GAP0 + 1));
        // 1 + 49*2 + 8 cycles per command
        check("b2b_period",  32'(last_period[0]), 32'd107);
        check("b2b_viol",    32'(viol[0]),        32'd0);

        // ---- CLK_DIV=1 boundary ----
        send(1, 24'hA5A5A5, "acc_div1");
        wait_frames(1, 1, "frame_div1");
        check("div1_word",   32'(rx_word[1]),    32'hA5A5A5);
        check("div1_falls",  32'(last_falls[1]), 32'd24);
        check("div1_cs_low", 32'(last_low[1]),   32'd49);
        check("div1_viol",   32'(viol[1]),       32'd0);

        // ---- reset mid-frame after bit 10 ----
        idle_cycles(20);
        begin
            int n = 0;
            send(0, 24'h0F0F0F, "acc_rstmid");
            while (falls[0] < 10 && n < 2000) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("rstmid_reach_bit10", 32'(falls[0] >= 10), 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_cs",   32'(spi_cs[0]),  32'd1);
        check("rstmid_clk",  32'(spi_clk[0]), 32'd0);
        check("rstmid_data", 32'(spi_dat[0]), 32'd0);
        check("rstmid_busy", 32'(busy_o[0]),  32'd0);
        idle_cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_ready", 32'(rdy[0]), 32'd1);
        f0 = frames[0];
        send(0, 24'h3CC399, "acc_postrst");
        wait_frames(0, f0 + 1, "frame_postrst");
        check("postrst_word",  32'(rx_word[0]),    32'h3CC399);
        check("postrst_falls", 32'(last_falls[0]), 32'd24);
        check("postrst_viol",  32'(viol[0]),       32'd0);

        // ---- cmd_valid pulsed while busy ----
        idle_cycles(20);
        f0 = frames[0];
        send(0, 24'h5AC381, "acc_busy");
        idle_cycles(10);
        check("busy_pulse_ready", 32'(rdy[0]),    32'd0);
        check("busy_pulse_busy",  32'(busy_o[0]), 32'd1);
        set_cmd(0, 1'b1, 24'hDEAD11);
        @(posedge clk);
        #1;
        set_cmd(0, 1'b0, 24'hDEAD11);
        wait_frames(0, f0 + 1, "frame_busy");
        idle_cycles(250);
        check("busy_no_extra", 32'(frames[0] - f0), 32'd1);
        check("busy_word",     32'(rx_word[0]),     32'h5AC381);
        check("final_viol0",   32'(viol[0]),        32'd0);
        check("final_viol1",   32'(viol[1]),        32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
